piezo_seq: RTL and testbench
============================

PIEZO_SEQ -- requirements
Module: piezo_seq

Interface
REQ-001 Parameter FAST_SIM, default 0: 1 shortens the tick prescaler to 16 clocks for simulation.
REQ-002 Parameter PRE_W, default 20: tick period is 2^PRE_W clocks when FAST_SIM=0.
REQ-003 Parameters HP_W, default 16 (half-period counter width), and DUR_TICKS, default 4 (note length in ticks).
REQ-004 Parameter REP_TICKS, default 48: NORM/BATT pattern repeat period in ticks, measured from pattern start; REP_TICKS > 3*DUR_TICKS.
REQ-005 Half-period parameters in clocks, each HP_W wide and >= 2: HP_NORM 23900, HP_OVR_A 28409, HP_OVR_B 18939, HP_B0 31888, HP_B1 37920, HP_B2 47778.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 norm_mode  input  1  request for the short periodic chirp.
REQ-009 ovr_spd  input  1  over-speed alarm request.
REQ-010 batt_low  input  1  low-battery alarm request.
REQ-011 piezo  output  1  piezo drive, positive leg.
REQ-012 piezo_n  output  1  piezo drive, negative leg.
REQ-013 active  output  1  high while a note is sounding.

Function
REQ-014 Prescaler shall run freely from reset and pulse tick for one clock each time it reaches all-ones: PRE_W bits, or 4 bits when FAST_SIM=1.
REQ-015 The FSM shall have states IDLE, NOTE and GAP, plus a pattern-step index and a tick counter cleared at each pattern start.
REQ-016 Pattern selection by priority, sampled at pattern start: ovr_spd&batt_low -> BOTH; ovr_spd only -> OVR; batt_low only -> BATT; norm_mode only -> NORM; none -> remain IDLE.
REQ-017 NORM pattern: HP_NORM for DUR_TICKS, then GAP until REP_TICKS.
REQ-018 OVR pattern: HP_OVR_A then HP_OVR_B, DUR_TICKS each, no GAP, re-evaluated immediately at the end.
REQ-019 BATT pattern: HP_B0, HP_B1, HP_B2, DUR_TICKS each, then GAP until REP_TICKS.
REQ-020 BOTH pattern: HP_B0, HP_B1, HP_B2, HP_OVR_A, HP_OVR_B, DUR_TICKS each, no GAP.
REQ-021 All state transitions shall occur only on a clock edge where tick=1; a request raised in IDLE starts its pattern on the next tick edge.
REQ-022 A started pattern shall run to completion even if its requests drop; at completion the next pattern is selected per REQ-016, or IDLE is entered.
REQ-023 Preemption: ovr_spd high while the latched pattern is NORM or BATT (NOTE or GAP) shall abort that pattern at the next tick edge and start OVR or BOTH per REQ-016.
REQ-024 During GAP, a request whose pattern differs from the latched pattern shall end GAP at the next tick edge and start the new pattern.
REQ-025 Tone generation: at each note start the half-period counter shall clear to 0 and piezo shall be set to 1.
REQ-026 The half-period counter shall increment each clock and, on reaching HP-1, clear to 0 and toggle piezo, giving a square wave of period 2*HP clocks.
REQ-027 While a note sounds, piezo_n shall equal ~piezo and active shall be 1.
REQ-028 In IDLE and GAP, piezo, piezo_n and active shall all be 0, and the half-period counter shall be held at 0.
REQ-029 All outputs shall be registered, with no combinational path from any input to any output.

Reset
REQ-030 rst_n low shall immediately force IDLE, clear the prescaler, tick counter, step index and half-period counter, and drive piezo=0, piezo_n=0, active=0.
REQ-031 Reset asserted mid-note shall silence the outputs immediately; after release no pattern shall start before the first tick edge.

Verification
REQ-032 Bench parameters: FAST_SIM=1, DUR_TICKS=2, REP_TICKS=10, HP_NORM=3, HP_OVR_A=4, HP_OVR_B=5, HP_B0=6, HP_B1=7, HP_B2=8; tick every 16 clocks.
REQ-033 Scenario: norm_mode=1 held -> 32-clock burst of period 6 (3 high/3 low), then 128 clocks silent, repeating every 160 clocks.
REQ-034 Scenario: batt_low=1 held -> three 32-clock notes of period 12, 14 and 16, then 64 clocks silent, repeating.
REQ-035 Scenario: ovr_spd=1 and batt_low=1 -> continuous notes of period 12, 14, 16, 8, 10; active stays 1 with no gap.
REQ-036 Scenario: norm_mode=1, then ovr_spd raised mid-GAP -> the OVR note of period 8 starts at the next tick edge; piezo_n equals ~piezo throughout.
REQ-037 Scenario: rst_n pulsed low mid-note -> piezo=piezo_n=active=0 within the same cycle; the pattern restarts only at the first tick edge after release.

Source files
------------

// File: rtl/piezo_seq.sv
// Piezo alarm sequencer: prescaled tick drives an IDLE/NOTE/GAP pattern FSM
// that plays NORM, OVR, BATT or BOTH tone sequences as registered square waves.
module piezo_seq #(
    parameter bit              FAST_SIM  = 1'b0,
    parameter int              PRE_W     = 20,
    parameter int              HP_W      = 16,
    parameter int              DUR_TICKS = 4,
    parameter int              REP_TICKS = 48,
    parameter logic [HP_W-1:0] HP_NORM   = HP_W'(23900),
    parameter logic [HP_W-1:0] HP_OVR_A  = HP_W'(28409),
    parameter logic [HP_W-1:0] HP_OVR_B  = HP_W'(18939),
    parameter logic [HP_W-1:0] HP_B0     = HP_W'(31888),
    parameter logic [HP_W-1:0] HP_B1     = HP_W'(37920),
    parameter logic [HP_W-1:0] HP_B2     = HP_W'(47778)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic norm_mode,
    input  logic ovr_spd,
    input  logic batt_low,
    output logic piezo,
    output logic piezo_n,
    output logic active
);

    localparam int PS_W = FAST_SIM ? 4 : PRE_W;
    localparam int TC_W = $clog2(REP_TICKS + 5 * DUR_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;
    typedef enum logic [2:0] {P_NONE, P_NORM, P_OVR, P_BATT, P_BOTH} pat_t;

    logic [PS_W-1:0] pre;
    logic            tick;
    state_t          state, state_d;
    pat_t            pat, pat_d, sel;
    logic [2:0]      step, step_d, last_step;
    logic [TC_W-1:0] tcnt, tcnt_d, tcnt_inc, step_end;
    logic [HP_W-1:0] hp, hp_cnt, hp_d;
    logic            has_gap, restart, note_start;
    logic            piezo_d, piezo_n_d, active_d;

    assign tick = &pre;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        sel = P_NONE;
        if (ovr_spd && batt_low) sel = P_BOTH;
        else if (ovr_spd)        sel = P_OVR;
        else if (batt_low)       sel = P_BATT;
        else if (norm_mode)      sel = P_NORM;
    end

    // BATT and BOTH share their first three notes, so one step table serves both.
    always_comb begin
        hp        = HP_NORM;
        last_step = 3'd0;
        case (pat)
            P_OVR: begin
                hp        = (step == 3'd0) ? HP_OVR_A : HP_OVR_B;
                last_step = 3'd1;
            end
            P_BATT, P_BOTH: begin
                last_step = (pat == P_BATT) ? 3'd2 : 3'd4;
                case (step)
                    3'd0:    hp = HP_B0;
                    3'd1:    hp = HP_B1;
                    3'd2:    hp = HP_B2;
                    3'd3:    hp = HP_OVR_A;
                    default: hp = HP_OVR_B;
                endcase
            end
            default: ;
        endcase
    end

    assign has_gap  = (pat == P_NORM) || (pat == P_BATT);
    assign tcnt_inc = tcnt + TC_W'(1);
    assign step_end = TC_W'(DUR_TICKS * (int'(step) + 1));

    always_comb begin
        state_d    = state;
        pat_d      = pat;
        step_d     = step;
        tcnt_d     = tcnt;
        restart    = 1'b0;
        note_start = 1'b0;
        if (tick) begin
            tcnt_d = tcnt_inc;
            case (state)
                S_IDLE: restart = 1'b1;
                S_NOTE: begin
                    if (has_gap && ovr_spd) begin
                        restart = 1'b1;
                    end else if (tcnt_inc == step_end) begin
                        if (step != last_step) begin
                            step_d     = step + 3'd1;
                            note_start = 1'b1;
                        end else if (has_gap) begin
                            state_d = S_GAP;
                        end else begin
                            restart = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (tcnt_inc == TC_W'(REP_TICKS) || (sel != P_NONE && sel != pat))
                        restart = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            if (restart) begin
                pat_d  = sel;
                step_d = 3'd0;
                tcnt_d = '0;
                if (sel == P_NONE) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_NOTE;
                    note_start = 1'b1;
                end
            end
        end
    end

    // Tone outputs are computed one cycle ahead so the pins come straight from flops.
    always_comb begin
        hp_d      = '0;
        piezo_d   = 1'b0;
        piezo_n_d = 1'b0;
        active_d  = 1'b0;
        if (note_start) begin
            piezo_d  = 1'b1;
            active_d = 1'b1;
        end else if (state_d == S_NOTE) begin
            active_d = 1'b1;
            if (hp_cnt == hp - HP_W'(1)) begin
                piezo_d = ~piezo;
            end else begin
                hp_d    = hp_cnt + HP_W'(1);
                piezo_d = piezo;
            end
            piezo_n_d = ~piezo_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            state   <= S_IDLE;
            pat     <= P_NONE;
            step    <= 3'd0;
            tcnt    <= '0;
            hp_cnt  <= '0;
            piezo   <= 1'b0;
            piezo_n <= 1'b0;
            active  <= 1'b0;
        end else begin
            pre     <= pre + PS_W'(1);
            state   <= state_d;
            pat     <= pat_d;
            step    <= step_d;
            tcnt    <= tcnt_d;
            hp_cnt  <= hp_d;
            piezo   <= piezo_d;
            piezo_n <= piezo_n_d;
            active  <= active_d;
        end
    end

endmodule

// File: tb/tb_piezo_seq.sv
// Scoreboard bench for piezo_seq: a note-list reference model predicts the pins
// every clock; a negedge monitor pops and compares against the DUT.
module tb_piezo_seq;

    localparam int TICK = 16;
    localparam int DUR  = 2;
    localparam int REP  = 10;
    localparam int HP_NORM = 3, HP_OVR_A = 4, HP_OVR_B = 5, HP_B0 = 6, HP_B1 = 7, HP_B2 = 8;
    localparam int P_NONE = 0, P_NORM = 1, P_OVR = 2, P_BATT = 3, P_BOTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic norm_mode = 1'b0, ovr_spd = 1'b0, batt_low = 1'b0;
    logic piezo, piezo_n, active;

    piezo_seq #(
        .FAST_SIM(1'b1), .PRE_W(20), .HP_W(16), .DUR_TICKS(DUR), .REP_TICKS(REP),
        .HP_NORM(16'(HP_NORM)), .HP_OVR_A(16'(HP_OVR_A)), .HP_OVR_B(16'(HP_OVR_B)),
        .HP_B0(16'(HP_B0)), .HP_B1(16'(HP_B1)), .HP_B2(16'(HP_B2))
    ) dut (
        .clk(clk), .rst_n(rst_n), .norm_mode(norm_mode), .ovr_spd(ovr_spd),
        .batt_low(batt_low), .piezo(piezo), .piezo_n(piezo_n), .active(active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b1;
    logic [2:0] exp_q[$];

    task automatic check(string name, logic [2:0] act, logic [2:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {piezo,piezo_n,active}=%b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference model: a pattern is a list of half-periods; the waveform is
    // derived arithmetically from the clocks elapsed since the note began.
    int m_n = 0;
    bit m_busy = 1'b0, m_gap = 1'b0;
    int m_pat = P_NONE, m_idx = 0, m_ticks = 0, m_t0 = 0;
    int m_notes[$];

    function automatic int sel_of(logic nm, logic ov, logic bl);
        if (ov && bl) return P_BOTH;
        if (ov)       return P_OVR;
        if (bl)       return P_BATT;
        if (nm)       return P_NORM;
        return P_NONE;
    endfunction

    function automatic void start_pat(int s);
        m_gap = 1'b0;
        m_pat = s;
        m_notes.delete();
        if (s == P_NONE) begin
            m_busy = 1'b0;
            return;
        end
        m_busy = 1'b1;
        m_idx = 0;
        m_ticks = 0;
        m_t0 = m_n;
        if (s == P_NORM) m_notes.push_back(HP_NORM);
        if (s == P_BATT || s == P_BOTH) begin
            m_notes.push_back(HP_B0);
            m_notes.push_back(HP_B1);
            m_notes.push_back(HP_B2);
        end
        if (s == P_OVR || s == P_BOTH) begin
            m_notes.push_back(HP_OVR_A);
            m_notes.push_back(HP_OVR_B);
        end
    endfunction

    function automatic void on_tick(int s);
        bit gapped;
        gapped = (m_pat == P_NORM) || (m_pat == P_BATT);
        if (!m_busy) begin
            start_pat(s);
            return;
        end
        m_ticks++;
        if (!m_gap) begin
            if (gapped && ovr_spd) start_pat(s);
            else if (m_ticks == (m_idx + 1) * DUR) begin
                if (m_idx + 1 < m_notes.size()) begin
                    m_idx++;
                    m_t0 = m_n;
                end else if (gapped) m_gap = 1'b1;
                else start_pat(s);
            end
        end else if (m_ticks == REP || (s != P_NONE && s != m_pat)) begin
            start_pat(s);
        end
    endfunction

    function automatic logic [2:0] model_out();
        int e, hp;
        logic p;
        if (!m_busy || m_gap) return 3'b000;
        e  = m_n - m_t0;
        hp = m_notes[m_idx];
        p  = ((e / hp) % 2) == 0;
        return {p, ~p, 1'b1};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n = 0;
            start_pat(P_NONE);
        end else begin
            m_n++;
            if (m_n % TICK == 0) on_tick(sel_of(norm_mode, ovr_spd, batt_low));
        end
        if (mon_en) exp_q.push_back(model_out());
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard: no expected entry at %0t", $time);
            end else begin
                check("pins", {piezo, piezo_n, active}, exp_q.pop_front());
            end
        end
    end

    task automatic drive(logic nm, logic ov, logic bl);
        @(negedge clk);
        #2;
        norm_mode = nm;
        ovr_spd   = ov;
        batt_low  = bl;
    endtask

    task automatic run(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_model(bit want_gap, string name);
        int k = 0;
        while (!(m_busy && m_gap == want_gap) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            n_checks++;
            $display("FAIL %s: timeout waiting for model phase", name);
        end
    endtask

    task automatic pulse_reset(int hold);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", {piezo, piezo_n, active}, 3'b000);
        run(hold);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        run(4);
        check("reset_state", {piezo, piezo_n, active}, 3'b000);
        #2;
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 1'b0);
        run(400);
        drive(1'b0, 1'b0, 1'b1);
        run(500);
        drive(1'b0, 1'b1, 1'b1);
        run(300);

        drive(1'b1, 1'b0, 1'b0);
        wait_model(1'b1, "norm_gap");
        run(20);
        drive(1'b1, 1'b1, 1'b0);
        run(100);

        wait_model(1'b0, "sounding");
        run(5);
        pulse_reset(3);
        drive(1'b1, 1'b0, 1'b0);
        run(200);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] req;
            req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) pulse_reset($urandom_range(1, 3));
            drive(req[0], req[1], req[2]);
            run($urandom_range(16, 240));
        end

        drive(1'b0, 1'b0, 1'b0);
        run(200);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
